// File: rtl/spi_pkg.sv
// spi_pkg: shared state/command types for spi_master_cfg.
// Build option SPI_MASTER_CFG_LOOPBACK_EN is handled in the top.
package spi_pkg;

  localparam int SPI_DATA_W = 8;
  localparam int SPI_NUM_CS = 4;
  localparam int SPI_DIV_W  = 8;
  localparam int SPI_CS_W   =
    (SPI_NUM_CS > 1) ? $clog2(SPI_NUM_CS) : 1;
  localparam int SPI_LEN_W  =
    (SPI_DATA_W > 1) ? $clog2(SPI_DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic [SPI_DATA_W-1:0] data;
    logic [SPI_LEN_W-1:0]  len_m1;
    logic [SPI_CS_W-1:0]   cs_sel;
    logic                  cpol;
    logic                  cpha;
    logic                  lsb_first;
    logic [SPI_DIV_W-1:0]  div;
  } spi_cmd_t;

  function automatic logic spi_busy_st(
    spi_state_e s
  );
    return (s == SETUP) || (s == XFER) ||
           (s == HOLD);
  endfunction

  // tx bit for the idx-th position on the wire
  function automatic logic spi_tx_bit(
    spi_cmd_t             c,
    logic [SPI_LEN_W-1:0] idx
  );
    logic [SPI_LEN_W-1:0] pos;
    pos = c.lsb_first ? idx : c.len_m1 - idx;
    return c.data[pos];
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period divider, sclk toggling and
// lead/trail edge pulses with edge count for spi_master_cfg.
module spi_sclk_gen
  import spi_pkg::*;
#(
  parameter int   DIV_WIDTH = SPI_DIV_W,
  parameter int   EDGE_W    = SPI_LEN_W + 1,
  parameter logic IDLE_CPOL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 load,
  input  logic                 load_cpol,
  input  logic                 active,
  input  logic                 xfer,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic [EDGE_W-1:0]    last_idx,
  output logic                 sclk,
  output logic                 div_hit,
  output logic                 lead_edge,
  output logic                 trail_edge,
  output logic [EDGE_W-1:0]    edge_cnt,
  output logic                 xfer_last
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [EDGE_W-1:0]    ecnt_q, ecnt_d;
  logic                 sclk_q, sclk_d;
  logic                 edge_p;

  always_comb begin
    div_hit = active && (cnt_q == div);
    edge_p  = xfer && div_hit;
    cnt_d   = cnt_q;
    ecnt_d  = ecnt_q;
    sclk_d  = sclk_q;
    if (load) begin
      cnt_d  = '0;
      ecnt_d = '0;
      sclk_d = load_cpol;
    end else begin
      if (active)
        cnt_d = div_hit ? '0 : cnt_q + 1'b1;
      if (edge_p) begin
        ecnt_d = ecnt_q + 1'b1;
        sclk_d = ~sclk_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      ecnt_q <= '0;
      sclk_q <= IDLE_CPOL;
    end else begin
      cnt_q  <= cnt_d;
      ecnt_q <= ecnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk       = sclk_q;
  assign edge_cnt   = ecnt_q;
  assign lead_edge  = edge_p && !ecnt_q[0];
  assign trail_edge = edge_p && ecnt_q[0];
  assign xfer_last  = edge_p && (ecnt_q == last_idx);

endmodule

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: per-command configurable SPI master.
// Define SPI_MASTER_CFG_LOOPBACK_EN to sample mosi instead of miso.
module spi_master_cfg
  import spi_pkg::*;
#(
  parameter int   DATA_WIDTH = SPI_DATA_W,
  parameter int   NUM_CS     = SPI_NUM_CS,
  parameter int   DIV_WIDTH  = SPI_DIV_W,
  parameter logic IDLE_CPOL  = 1'b0,
  localparam int  CS_W  =
    (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int  LEN_W =
    (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic [LEN_W-1:0]      bit_len_m1,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsb_first,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  output logic                  busy,
  output logic                  spi_done,
  output logic [DATA_WIDTH-1:0] data_recv,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     csn,
  output logic                  mosi,
  input  logic                  miso
);

  localparam int EDGE_W = LEN_W + 1;

  spi_state_e            state_q, state_d;
  spi_cmd_t              cmd_q, cmd_d, cmd_in;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] recv_q, recv_d;
  logic [NUM_CS-1:0]     csn_q, csn_d;
  logic                  done_q, done_d;
  logic                  accept, rx_src;
  logic [LEN_W-1:0]      pair, nxt;
  logic                  div_hit, lead_edge;
  logic                  trail_edge, xfer_last;
  logic [EDGE_W-1:0]     edge_cnt;

`ifdef SPI_MASTER_CFG_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign rx_src      = mosi_q;
`else
  assign rx_src      = miso;
`endif

  spi_sclk_gen #(
    .DIV_WIDTH (DIV_WIDTH),
    .EDGE_W    (EDGE_W),
    .IDLE_CPOL (IDLE_CPOL)
  ) u_sclk (
    .clk        (clk),
    .rstn       (rstn),
    .load       (accept),
    .load_cpol  (cmd_d.cpol),
    .active     (spi_busy_st(state_q)),
    .xfer       (state_q == XFER),
    .div        (cmd_q.div),
    .last_idx   ({cmd_q.len_m1, 1'b1}),
    .sclk       (sclk),
    .div_hit    (div_hit),
    .lead_edge  (lead_edge),
    .trail_edge (trail_edge),
    .edge_cnt   (edge_cnt),
    .xfer_last  (xfer_last)
  );

  always_comb begin
    cmd_in = '{
      data:      data_send,
      len_m1:    bit_len_m1,
      cs_sel:    cs_sel,
      cpol:      cpol,
      cpha:      cpha,
      lsb_first: lsb_first,
      div:       clk_div
    };
    accept = cmd_valid && (state_q == IDLE);
    cmd_d  = accept ? cmd_in : cmd_q;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = SETUP;
      SETUP:   if (div_hit)   state_d = XFER;
      XFER:    if (xfer_last) state_d = HOLD;
      HOLD:    if (div_hit)   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // CPHA=1 already drove bit 0 at accept
    pair   = edge_cnt[EDGE_W-1:1];
    nxt    = cmd_q.cpha ? pair : pair + LEN_W'(1);
    mosi_d = mosi_q;
    rx_d   = rx_q;
    if (accept) begin
      mosi_d = spi_tx_bit(cmd_in, '0);
      rx_d   = '0;
    end else begin
      if ((lead_edge && cmd_q.cpha &&
           pair != '0) ||
          (trail_edge && !cmd_q.cpha &&
           pair != cmd_q.len_m1))
        mosi_d = spi_tx_bit(cmd_q, nxt);
      if ((lead_edge && !cmd_q.cpha) ||
          (trail_edge && cmd_q.cpha)) begin
        if (cmd_q.lsb_first)
          rx_d[pair] = rx_src;
        else
          rx_d = {rx_q[DATA_WIDTH-2:0], rx_src};
      end
    end
    if (state_d == DONE) mosi_d = 1'b0;

    for (int i = 0; i < NUM_CS; i++)
      csn_d[i] = !(spi_busy_st(state_d) &&
                   cmd_d.cs_sel == CS_W'(i));

    done_d = (state_q == DONE);
    recv_d = done_d ? rx_q : recv_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      mosi_q  <= 1'b0;
      rx_q    <= '0;
      recv_q  <= '0;
      csn_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      recv_q  <= recv_d;
      csn_q   <= csn_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) || done_q;
  assign spi_done  = done_q;
  assign data_recv = recv_q;
  assign csn       = csn_q;
  assign mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed vectors for spi_master_cfg
// against a cycle-sampled behavioural SPI slave.
module tb_spi_master_cfg;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] data_send = '0;
  logic [2:0] bit_len_m1 = '0;
  logic [1:0] cs_sel = '0;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] clk_div = '0;
  logic       busy, spi_done;
  logic [7:0] data_recv;
  logic       sclk, mosi;
  logic [3:0] csn;
  logic       miso = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_done = 0;
  int t_rise = 0;
  int t_fall = 0;

  logic [7:0] s_word = '0;
  logic [7:0] s_cap = '0;
  logic       s_cpol = 1'b0;
  logic       s_cpha = 1'b0;
  logic       s_lsb = 1'b0;
  logic       s_x = 1'b0;
  logic       s_act = 1'b0;
  logic       s_sclk = 1'b0;
  int         s_n = 8;
  int         s_idx = 0;

  spi_master_cfg dut (
    .clk        (clk),
    .rstn       (rstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .data_send  (data_send),
    .bit_len_m1 (bit_len_m1),
    .cs_sel     (cs_sel),
    .cpol       (cpol),
    .cpha       (cpha),
    .lsb_first  (lsb_first),
    .clk_div    (clk_div),
    .busy       (busy),
    .spi_done   (spi_done),
    .data_recv  (data_recv),
    .sclk       (sclk),
    .csn        (csn),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h",
               tag, got, exp);
    end
  endtask

  task automatic s_drive(input int i);
    logic [7:0] w;
    w = s_word;
    if (s_x)
      miso = 1'bx;
    else
      miso = s_lsb ? w[i] : w[s_n-1-i];
  endtask

  // slave: looks at pins 1ns after each clk edge
  initial begin
    logic lead;
    forever begin
      @(posedge clk);
      #1;
      if (!(&csn) && !s_act) begin
        s_idx  = 0;
        s_cap  = '0;
        t_fall = cyc;
        if (!s_cpha) s_drive(0);
      end else if (!(&csn) && sclk !== s_sclk) begin
        lead = (sclk !== s_cpol);
        if (lead ^ s_cpha) begin
          s_cap = {s_cap[6:0], mosi};
          if (s_cpha) s_idx++;
        end else if (s_cpha) begin
          if (s_idx < s_n) s_drive(s_idx);
        end else begin
          s_idx++;
          if (s_idx < s_n) s_drive(s_idx);
        end
      end else if ((&csn) && s_act) begin
        t_rise = cyc;
      end
      s_act  = !(&csn);
      s_sclk = sclk;
    end
  end

  task automatic xfer(
    input  logic       cp, ph, lsb,
    input  logic [2:0] lm1,
    input  logic [1:0] cs,
    input  logic [7:0] dv, tx, sw,
    input  bit         hold,
    output int         lat,
    output logic [3:0] cs_at,
    output logic       mosi_at,
    output logic       rdy_seen
  );
    int w;
    s_cpol = cp;
    s_cpha = ph;
    s_lsb  = lsb;
    s_n    = int'(lm1) + 1;
    s_word = sw;
    @(negedge clk);
    cpol       = cp;
    cpha       = ph;
    lsb_first  = lsb;
    bit_len_m1 = lm1;
    cs_sel     = cs;
    clk_div    = dv;
    data_send  = tx;
    cmd_valid  = 1'b1;
    w = 0;
    while (!cmd_ready && w < 5000) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1;
    t_acc    = cyc;
    cs_at    = csn;
    mosi_at  = mosi;
    rdy_seen = 1'b0;
    lat      = -1;
    if (hold) data_send = ~tx;
    else      cmd_valid = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      @(posedge clk);
      #1;
      if (spi_done) begin
        t_done = cyc;
        lat    = cyc - t_acc;
        break;
      end
      rdy_seen |= cmd_ready;
    end
  endtask

  initial begin
    int         lat, t_prev, rise_prev;
    logic [3:0] cs_at;
    logic       m_at, rdy, seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", spi_done, 0);
    check("rst_recv", data_recv, 8'h00);
    check("rst_sclk", sclk, 0);
    check("rst_csn", csn, 4'hF);
    check("rst_mosi", mosi, 0);
    @(negedge clk);
    rstn = 1'b1;

    // mode 0, MSB first, 8 bits, div 4, cs 0
    xfer(0, 0, 0, 3'd7, 2'd0, 8'd4, 8'hA5, 8'h3C,
         0, lat, cs_at, m_at, rdy);
    check("t1_lat", lat, 91);
    check("t1_rx", data_recv, 8'h3C);
    check("t1_csn", cs_at, 4'hE);
    check("t1_mosi0", m_at, 1);
    check("t1_mosiseq", s_cap, 8'hA5);
    check("t1_rdy", rdy, 0);
    check("t1_busy_done", busy, 1);
    @(posedge clk);
    #1;
    check("t1_busy_off", busy, 0);
    check("t1_csn_idle", csn, 4'hF);

    // mode 3, LSB first, div 1, cs 2
    xfer(1, 1, 1, 3'd7, 2'd2, 8'd1, 8'h81, 8'h5A,
         0, lat, cs_at, m_at, rdy);
    check("t2_lat", lat, 37);
    check("t2_rx", data_recv, 8'h5A);
    check("t2_csn", cs_at, 4'hB);
    check("t2_mosi0", m_at, 1);
    check("t2_mosiseq", s_cap, 8'h81);
    check("t2_sclk_idle", sclk, 1);

    // mode 1, MSB first, 4 bits, div 2
    xfer(0, 1, 0, 3'd3, 2'd1, 8'd2, 8'hF6, 8'h09,
         0, lat, cs_at, m_at, rdy);
    check("t3_lat", lat, 31);
    check("t3_rx", data_recv, 8'h09);
    check("t3_csn", cs_at, 4'hD);
    check("t3_mosiseq", s_cap, 8'h06);
    check("t3_sclk_idle", sclk, 0);

    // valid held through transfer with changed data
    xfer(0, 0, 0, 3'd7, 2'd1, 8'd1, 8'h3C, 8'h96,
         1, lat, cs_at, m_at, rdy);
    check("t4a_lat", lat, 37);
    check("t4a_rdy", rdy, 0);
    check("t4a_rx", data_recv, 8'h96);
    check("t4a_mosiseq", s_cap, 8'h3C);
    t_prev    = t_done;
    rise_prev = t_rise;
    xfer(1, 1, 1, 3'd3, 2'd3, 8'd0, 8'h0B, 8'h05,
         0, lat, cs_at, m_at, rdy);
    check("t4b_acc", t_acc - t_prev, 1);
    check("t4b_gap", t_fall - rise_prev, 2);
    check("t4b_lat", lat, 11);
    check("t4b_csn", cs_at, 4'h7);
    check("t4b_rx", data_recv, 8'h05);
    check("t4b_mosiseq", s_cap, 8'h0D);

    // reset in the middle of bit 3
    s_cpol = 0;
    s_cpha = 0;
    s_lsb  = 0;
    s_n    = 8;
    s_word = 8'hFF;
    @(negedge clk);
    cpol       = 0;
    cpha       = 0;
    lsb_first  = 0;
    bit_len_m1 = 3'd7;
    cs_sel     = 2'd1;
    clk_div    = 8'd1;
    data_send  = 8'hFF;
    cmd_valid  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    check("t5_pre_sclk", sclk, 1);
    check("t5_pre_csn", csn, 4'hD);
    #1;
    rstn = 1'b0;
    #1;
    check("t5_csn", csn, 4'hF);
    check("t5_sclk", sclk, 0);
    check("t5_busy", busy, 0);
    check("t5_ready", cmd_ready, 1);
    check("t5_recv", data_recv, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= spi_done;
    end
    check("t5_no_done", seen, 0);
    xfer(0, 0, 0, 3'd7, 2'd0, 8'd4, 8'hA5, 8'h3C,
         0, lat, cs_at, m_at, rdy);
    check("t5_lat", lat, 91);
    check("t5_rx", data_recv, 8'h3C);

    // div 0: SCLK = clk/2
`ifdef SPI_MASTER_CFG_LOOPBACK_EN
    s_x = 1'b1;
`endif
    xfer(0, 0, 0, 3'd7, 2'd0, 8'd0, 8'hC3, 8'hC3,
         0, lat, cs_at, m_at, rdy);
    check("t6m_lat", lat, 19);
    check("t6m_rx", data_recv, 8'hC3);
    check("t6m_mosiseq", s_cap, 8'hC3);
    xfer(0, 0, 1, 3'd7, 2'd0, 8'd0, 8'hC3, 8'hC3,
         0, lat, cs_at, m_at, rdy);
    check("t6l_lat", lat, 19);
    check("t6l_rx", data_recv, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
